// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte FIFO behind a UART receiver, sticky overflow.
// Optional build macro UART_RX_FIFO_ERR_DROP_EN: discard framing-error bytes instead of storing them.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       rxDone,
  input  logic                       rxErr,
  input  logic [7:0]                 rxByte,
  input  logic                       outReady,
  output logic                       outValid,
  output logic [7:0]                 outData,
  output logic                       outErr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clrOverflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef UART_RX_FIFO_ERR_DROP_EN
  localparam int DW = 8;
`else
  localparam int DW = 9;
`endif

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rx_done_prev;
  logic          r_overflow;

  logic          w_wr_strobe;
  logic          w_accept;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_write;
  logic          w_ovf;
  logic [DW-1:0] w_wr_data;
  logic [DW-1:0] w_head;

  assign w_wr_strobe = rxDone & ~r_rx_done_prev;
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_pop       = ~w_empty & outReady;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  // Errored bytes vanish entirely: no store, no overflow contribution.
  assign w_accept  = w_wr_strobe & ~rxErr;
  assign w_wr_data = rxByte;
`else
  assign w_accept  = w_wr_strobe;
  assign w_wr_data = {rxErr, rxByte};
`endif

  // A pop on the same edge frees the slot, so a full FIFO can still take the byte.
  assign w_write = w_accept & (~w_full | w_pop);
  assign w_ovf   = w_accept & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_rx_done_prev <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_rx_done_prev <= rxDone;
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end else if (clrOverflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign outValid = ~w_empty;
  assign outData  = w_head[7:0];
`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign outErr   = 1'b0;
`else
  assign outErr   = w_head[8];
`endif
  assign count    = r_count;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (DEPTH=16), directed vectors.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rstN;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxByte;
  logic       outReady;
  logic       outValid;
  logic [7:0] outData;
  logic       outErr;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       clrOverflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] sb_q[$];

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .outReady(outReady), .outValid(outValid), .outData(outData), .outErr(outErr),
    .count(count), .full(full), .overflow(overflow), .clrOverflow(clrOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any accepted head entry is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (rstN === 1'b1 && outValid === 1'b1 && outReady === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got data %0h err %0b expected nothing", outData, outErr);
      end else begin
        check("sb_data", {24'd0, outData}, {24'd0, sb_q[0][7:0]});
        check("sb_err", {31'd0, outErr}, {31'd0, sb_q[0][8]});
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic e, input int width, input bit exp_store);
    rxByte = b;
    rxErr  = e;
    rxDone = 1'b1;
    if (exp_store) sb_q.push_back({e, b});
    repeat (width) step();
    rxDone = 1'b0;
    rxErr  = 1'b0;
    step();
  endtask

  task automatic drain(input int n);
    outReady = 1'b1;
    repeat (n) step();
    outReady = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
    outReady = 1'b0; clrOverflow = 1'b0;
    #22;
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_valid", {31'd0, outValid}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rstN = 1'b1;
    step();

    // Long rxDone pulse yields a single entry
    write_byte(8'h56, 1'b0, 3, 1'b1);
    check("pulse_count", {27'd0, count}, 32'd1);
    check("pulse_valid", {31'd0, outValid}, 32'd1);
    check("pulse_data", {24'd0, outData}, 32'h56);
    check("pulse_err", {31'd0, outErr}, 32'd0);
    drain(1);
    check("pulse_drained", {27'd0, count}, 32'd0);

    // Fill, then overflow with 0x11
    for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b0, 1, 1'b1);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", {27'd0, count}, 32'd16);
    check("fill_ovf", {31'd0, overflow}, 32'd0);
    write_byte(8'h11, 1'b0, 1, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    drain(16);
    check("ovf_drained", {27'd0, count}, 32'd0);
    check("ovf_sb_empty", sb_q.size(), 32'd0);
    clrOverflow = 1'b1;
    step();
    clrOverflow = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Write into a full FIFO with a simultaneous pop
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i), 1'b0, 1, 1'b1);
    rxByte = 8'hA5; rxDone = 1'b1; outReady = 1'b1;
    sb_q.push_back({1'b0, 8'hA5});
    step();
    rxDone = 1'b0; outReady = 1'b0;
    step();
    check("wp_count", {27'd0, count}, 32'd16);
    check("wp_ovf", {31'd0, overflow}, 32'd0);
    drain(16);
    check("wp_sb_empty", sb_q.size(), 32'd0);

    // Framing-error byte
`ifdef UART_RX_FIFO_ERR_DROP_EN
    write_byte(8'h3C, 1'b1, 1, 1'b0);
    check("err_drop_count", {27'd0, count}, 32'd0);
    check("err_drop_ovf", {31'd0, overflow}, 32'd0);
`else
    write_byte(8'h3C, 1'b1, 1, 1'b1);
    check("err_count", {27'd0, count}, 32'd1);
    check("err_flag", {31'd0, outErr}, 32'd1);
    check("err_data", {24'd0, outData}, 32'h3C);
    drain(1);
`endif

    // Clear colliding with a new overflow
    for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i), 1'b0, 1, 1'b1);
    write_byte(8'h50, 1'b0, 1, 1'b0);
    check("clr_pre_ovf", {31'd0, overflow}, 32'd1);
    rxByte = 8'h51; rxDone = 1'b1; clrOverflow = 1'b1;
    step();
    clrOverflow = 1'b0;
    check("clr_collide_ovf", {31'd0, overflow}, 32'd1);
    rxDone = 1'b0;
    step();
    clrOverflow = 1'b1;
    step();
    clrOverflow = 1'b0;
    check("clr_alone_ovf", {31'd0, overflow}, 32'd0);
    drain(16);
    check("clr_sb_empty", sb_q.size(), 32'd0);

    // Mid-operation reset, with rxDone already high at release
    for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i), 1'b0, 1, 1'b0);
    check("mid_count", {27'd0, count}, 32'd5);
    #2;
    rstN = 1'b0;
    #1;
    check("async_count", {27'd0, count}, 32'd0);
    check("async_valid", {31'd0, outValid}, 32'd0);
    rxByte = 8'h77; rxDone = 1'b1;
    sb_q.push_back({1'b0, 8'h77});
    step();
    rstN = 1'b1;
    step();
    rxDone = 1'b0;
    check("release_count", {27'd0, count}, 32'd1);
    drain(1);
    check("release_drained", {27'd0, count}, 32'd0);

    // Pointer wrap through 40 write/pop pairs
    outReady = 1'b1;
    for (int i = 0; i < 40; i++) write_byte(8'(i), 1'b0, 1, 1'b1);
    step();
    outReady = 1'b0;
    check("wrap_count", {27'd0, count}, 32'd0);
    check("wrap_sb_empty", sb_q.size(), 32'd0);
    check("wrap_ovf", {31'd0, overflow}, 32'd0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
